// File: rtl/gcd_pkg.sv
// Shared encodings for the GCD controller: state values, datapath width and mux selects.
package gcd_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    CALC   = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic SEL_A       = 1'b0;
  localparam logic SEL_B       = 1'b1;
  localparam logic SEL_IN_DATA = 1'b1;
  localparam logic SEL_IN_SUB  = 1'b0;

endpackage

// File: rtl/iter_counter.sv
// Saturating iteration counter used by the GCD controller to bound the subtraction loop.
module iter_counter #(
  parameter int ITER_W   = 16,
  parameter int MAX_ITER = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic at_limit
);

  localparam logic [ITER_W-1:0] LIMIT = ITER_W'(MAX_ITER);

  logic [ITER_W-1:0] count;

  // Holds at LIMIT so a stuck loop can never wrap back and miss the timeout.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (inc && !at_limit) begin
      count <= count + ITER_W'(1);
    end
  end

  assign at_limit = (count == LIMIT);

endmodule

// File: rtl/gcd_ctrl_fsm.sv
// Controller FSM for the subtract-and-compare GCD datapath: operand handshake, loop, done/err.
module gcd_ctrl_fsm
  import gcd_pkg::*;
#(
  parameter int ITER_W   = 16,
  parameter int MAX_ITER = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic in_valid,
  output logic in_ready,
  input  logic lt,
  input  logic gt,
  input  logic eq,
  output logic ldA,
  output logic ldB,
  output logic sel1,
  output logic sel2,
  output logic sel_in,
  output logic busy,
  output logic done,
  output logic err
);

  state_t state, next_state;
  logic   err_flag;
  logic   set_err, clr_err;
  logic   cnt_clear, cnt_inc;
  logic   at_limit;
  logic   eq_only;

  iter_counter #(
    .ITER_W  (ITER_W),
    .MAX_ITER(MAX_ITER)
  ) u_iter_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (cnt_clear),
    .inc     (cnt_inc),
    .at_limit(at_limit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      err_flag <= 1'b0;
    end else begin
      state <= next_state;
      if (set_err) begin
        err_flag <= 1'b1;
      end else if (clr_err) begin
        err_flag <= 1'b0;
      end
    end
  end

  // A flag combination other than eq alone is illegal and must not end the loop.
  assign eq_only = eq && !gt && !lt;

  // Reset forces every output low combinationally, even while mid-computation.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    ldA        = 1'b0;
    ldB        = 1'b0;
    sel1       = SEL_A;
    sel2       = SEL_A;
    sel_in     = SEL_IN_SUB;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    set_err    = 1'b0;
    clr_err    = 1'b0;
    cnt_clear  = 1'b0;
    cnt_inc    = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (start) begin
            next_state = LOAD_A;
            cnt_clear  = 1'b1;
            clr_err    = 1'b1;
          end
        end
        LOAD_A: begin
          busy     = 1'b1;
          in_ready = 1'b1;
          sel_in   = SEL_IN_DATA;
          ldA      = in_valid;
          if (in_valid) next_state = LOAD_B;
        end
        LOAD_B: begin
          busy     = 1'b1;
          in_ready = 1'b1;
          sel_in   = SEL_IN_DATA;
          ldB      = in_valid;
          if (in_valid) next_state = CALC;
        end
        CALC: begin
          busy = 1'b1;
          if (eq_only) begin
            next_state = DONE;
          end else if (at_limit) begin
            next_state = DONE;
            set_err    = 1'b1;
          end else if (gt) begin
            sel1    = SEL_A;
            sel2    = SEL_B;
            ldA     = 1'b1;
            cnt_inc = 1'b1;
          end else if (lt) begin
            sel1    = SEL_B;
            sel2    = SEL_A;
            ldB     = 1'b1;
            cnt_inc = 1'b1;
          end
        end
        DONE: begin
          busy       = 1'b1;
          done       = 1'b1;
          err        = err_flag;
          next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_ctrl_fsm.sv
// Directed bench for gcd_ctrl_fsm with a behavioural datapath and a result scoreboard.
module tb_gcd_ctrl_fsm;

  localparam int ITER_W   = 16;
  localparam int MAX_ITER = 8;

  logic clk = 1'b0;
  logic rst, start, in_valid;
  logic in_ready, lt, gt, eq, ldA, ldB, sel1, sel2, sel_in, busy, done, err;
  logic [15:0] data_in;
  logic [15:0] a_reg = '0;
  logic [15:0] b_reg = '0;
  logic [15:0] sub_out, bus;

  typedef struct {
    logic [15:0] result;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;
  int   checks   = 0;
  int   failures = 0;

  gcd_ctrl_fsm #(
    .ITER_W  (ITER_W),
    .MAX_ITER(MAX_ITER)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .lt      (lt),
    .gt      (gt),
    .eq      (eq),
    .ldA     (ldA),
    .ldB     (ldB),
    .sel1    (sel1),
    .sel2    (sel2),
    .sel_in  (sel_in),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Behavioural datapath: two registers, a muxed subtractor and comparison flags.
  assign lt      = (a_reg < b_reg);
  assign gt      = (a_reg > b_reg);
  assign eq      = (a_reg == b_reg);
  assign sub_out = (sel1 ? b_reg : a_reg) - (sel2 ? b_reg : a_reg);
  assign bus     = sel_in ? data_in : sub_out;

  always @(posedge clk) begin
    if (ldA) a_reg <= bus;
    if (ldB) b_reg <= bus;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic exp_t refGcd(input logic [15:0] a, input logic [15:0] b);
    exp_t        r;
    logic [15:0] x, y, t;
    x = a;
    y = b;
    if (a == b) begin
      r.result = a;
      r.err    = 1'b0;
    end else if (a == 16'd0 || b == 16'd0) begin
      r.result = a;
      r.err    = 1'b1;
    end else begin
      while (y != 16'd0) begin
        t = x % y;
        x = y;
        y = t;
      end
      r.result = x;
      r.err    = 1'b0;
    end
    return r;
  endfunction

  // Scoreboard consumer plus a per-cycle exclusivity check on the load enables.
  always @(negedge clk) begin
    checkOutput("ld_exclusive", 32'(ldA & ldB), 32'd0);
    if (done) begin
      if (sb_q.size() == 0) begin
        checkOutput("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        sb_e = sb_q.pop_front();
        checkOutput("result_A", 32'(a_reg), 32'(sb_e.result));
        checkOutput("result_err", 32'(err), 32'(sb_e.err));
      end
    end
  end

  task automatic loadOperands(input logic [15:0] a, input logic [15:0] b, input int stall_a, input int stall_b);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < stall_a; i++) begin
      @(negedge clk);
      checkOutput("stall_a_ready", 32'(in_ready), 32'd1);
      checkOutput("stall_a_ldA", 32'(ldA | ldB), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    data_in  = a;
    @(negedge clk);
    checkOutput("load_a_ldA", 32'(ldA), 32'd1);
    checkOutput("load_a_selin", 32'(sel_in), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < stall_b; i++) begin
      @(negedge clk);
      checkOutput("stall_b_ready", 32'(in_ready), 32'd1);
      checkOutput("stall_b_ldB", 32'(ldA | ldB), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    data_in  = b;
    @(negedge clk);
    checkOutput("load_b_ldB", 32'(ldB), 32'd1);
    checkOutput("load_b_ldA", 32'(ldA), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic runToDone(input int exp_subs, input int exp_lat, input bit poke);
    int edges = 0;
    int subs  = 0;
    if (poke) start = 1'b1;
    while (edges < 100) begin
      @(negedge clk);
      if (done) break;
      if (ldA || ldB) subs++;
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0;
    checkOutput("done_seen", 32'(done), 32'd1);
    checkOutput("latency", 32'(edges), 32'(exp_lat));
    checkOutput("subtractions", 32'(subs), 32'(exp_subs));
    checkOutput("done_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("done_single", 32'(done), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_err", 32'(err), 32'd0);
    if (poke) begin
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("poke_no_restart", 32'({busy, ldA, ldB, in_ready}), 32'd0);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input int stall_a,
                               input int stall_b, input int exp_subs, input int exp_lat, input bit poke);
    sb_q.push_back(refGcd(a, b));
    loadOperands(a, b, stall_a, stall_b);
    runToDone(exp_subs, exp_lat, poke);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b1;
    in_valid = 1'b0;
    data_in  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_outputs", 32'({in_ready, ldA, ldB, sel1, sel2, sel_in, busy, done, err}), 32'd0);
    @(posedge clk); #1;
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checkOutput("start_during_rst_ignored", 32'(busy), 32'd0);

    applyStimulus(16'd48, 16'd18, 0, 0, 4, 5, 1'b0);
    applyStimulus(16'd25, 16'd25, 0, 0, 0, 1, 1'b0);
    applyStimulus(16'd0,  16'd5,  0, 0, 8, 9, 1'b0);
    applyStimulus(16'd21, 16'd14, 3, 2, 2, 3, 1'b0);

    loadOperands(16'd100, 16'd3, 0, 0);
    @(negedge clk);
    checkOutput("rst_first_sub", 32'(ldA), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_dominates", 32'({in_ready, ldA, ldB, sel1, sel2, sel_in, busy, done, err}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("after_rst_outputs", 32'({in_ready, ldA, ldB, sel1, sel2, sel_in, busy, done, err}), 32'd0);

    applyStimulus(16'd9,  16'd6,  0, 0, 2, 3, 1'b0);
    applyStimulus(16'd48, 16'd18, 0, 0, 4, 5, 1'b1);

    checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gcd_ctrl_fsm.md
Name: gcd_ctrl_fsm

Overview:
- Controller FSM that sequences the 16-bit subtract-and-compare GCD datapath.
- Accepts two operands over a valid/ready input handshake and steers the datapath's load enables and mux selects.
- Runs the repeated-subtraction loop until the datapath reports equality, then pulses done.
- An iteration limit catches non-terminating cases (one operand zero) and reports them as an error.

Parameters:
- ITER_W, 16, width of the iteration counter.
- MAX_ITER, 65535, maximum subtraction cycles before timeout; covers the worst case for 16-bit nonzero operands (65534 subtractions).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin a computation; sampled only in IDLE.
- in_valid  in  1  operand present on the datapath data_in bus.
- in_ready  out  1  controller is accepting an operand this cycle.
- lt  in  1  datapath flag, A < B.
- gt  in  1  datapath flag, A > B.
- eq  in  1  datapath flag, A == B.
- ldA  out  1  load register A from bus.
- ldB  out  1  load register B from bus.
- sel1  out  1  subtractor minuend select (0 = A, 1 = B).
- sel2  out  1  subtractor subtrahend select (0 = A, 1 = B).
- sel_in  out  1  bus source select (1 = data_in, 0 = subtractor output).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; result is valid in register A.
- err  out  1  one-cycle pulse coincident with done when the iteration limit is hit.

Behaviour:
- Reset: synchronous, active-high; dominates all other inputs.
  - Next state IDLE and iteration counter cleared.
  - All outputs 0, including mid-computation; the datapath register contents are then don't-care.
- States: IDLE, LOAD_A, LOAD_B, CALC, DONE.
- IDLE:
  - All outputs 0.
  - start=1 moves to LOAD_A and clears the iteration counter and the err flag.
- LOAD_A:
  - in_ready=1, sel_in=1, ldA=in_valid.
  - in_valid=1 moves to LOAD_B; otherwise the FSM waits.
- LOAD_B:
  - in_ready=1, sel_in=1, ldB=in_valid.
  - in_valid=1 moves to CALC; otherwise the FSM waits.
- CALC: outputs are Mealy on flags; sel_in=0 throughout. Priority per cycle:
  - eq=1: no load; next state DONE; err flag stays 0.
  - Else if count == MAX_ITER: no load; next DONE with err flag set.
  - Else if gt=1: A <= A-B (sel1=0, sel2=1, ldA=1); count+1.
  - Else if lt=1: B <= B-A (sel1=1, sel2=0, ldB=1); count+1.
- DONE:
  - done=1 and err=err flag, for exactly one cycle.
  - busy=1 in DONE, then IDLE next cycle.
  - Result (GCD) is held in register A until the next operand load.
- Latency: with N subtractions, done rises on the (N+1)th rising edge after the edge that loads B.
- Never assert ldA and ldB in the same cycle.
- In LOAD_*, sel1/sel2 are 0; in IDLE and DONE, all selects are 0.
- start while busy is ignored; in IDLE, start sampled at the same time as rst is ignored.
- Operand edge cases:
  - A=0, B=0: eq is seen immediately; done with result 0, err=0.
  - Exactly one operand zero: loop never converges, ends via timeout with err=1.
- Iteration counter: ITER_W bits; saturates at MAX_ITER and never wraps.
- Flags with none or more than one asserted (illegal): treated as eq=0; priority gt over lt.

Decomposition:
- Shared package gcd_pkg:
  - state encoding localparams (IDLE=0, LOAD_A=1, LOAD_B=2, CALC=3, DONE=4, 3-bit);
  - DATA_W=16 constant;
  - mux select encodings (SEL_A=0, SEL_B=1, SEL_IN_DATA=1, SEL_IN_SUB=0).
- One sub-module is natural: iter_counter (clear, enable, saturate-at-limit, at_limit output).
- The FSM's next-state and output logic stays in gcd_ctrl_fsm.

Test Plan:
- Normal run: A=48, B=18, in_valid held high.
  - Required: 4 subtractions (A 30, A 12, B 6, A 6); done on the 5th edge after B load; A=6; err=0.
- Equal operands: A=25, B=25 -> 0 subtractions, done 1 edge after B load, A=25, err=0.
- Timeout: MAX_ITER=8, A=0, B=5 -> exactly 8 ldB pulses, then done=1 and err=1 in the same cycle.
- Handshake stalls: in_valid low for 3 cycles in LOAD_A and 2 in LOAD_B.
  - Required: in_ready stays high and no ldA/ldB pulse while in_valid is low; operands 21, 14 give A=7.
- Reset mid-CALC: assert rst during the 2nd subtraction of (100, 3).
  - Required: next cycle all outputs 0, busy=0.
  - Required: a following start with (9, 6) gives A=3, err=0.
- start pulsed during CALC and DONE -> ignored: no extra operand load, single done pulse.
